// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the request sources and the round-robin arbiter.
// The grant side carries the decoder enable, the binary select and the decoded one-hot.
interface decoder_rr_arbiter_if;
  logic [15:0] req;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic        timeout;

  modport master (
    output req,
    input  grant_valid,
    input  grant_idx,
    input  grant_onehot,
    input  timeout
  );

  modport slave (
    input  req,
    output grant_valid,
    output grant_idx,
    output grant_onehot,
    output timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// 16-way round-robin arbiter with bounded tenure and a two-cycle dead gap,
// driving a 4-to-16 decoder select (index + enable) and its registered one-hot form.
module decoder_rr_arbiter #(
  parameter logic [7:0] MAX_HOLD = 8'd8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [15:0] onehot_q, onehot_d;
  logic [7:0]  hold_q, hold_d;
  logic        timeout_q, timeout_d;

  logic        pick_found;
  logic [3:0]  pick_idx;
  logic [3:0]  cand;

  // First requester at or after ptr_q, wrapping through 15 back to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = '0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    onehot_d  = onehot_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d  = 1'b0;
        onehot_d = '0;
        if (pick_found) begin
          idx_d    = pick_idx;
          valid_d  = 1'b1;
          onehot_d = 16'd1 << pick_idx;
          hold_d   = 8'd1;
          state_d  = S_GRANT;
        end
      end

      S_GRANT: begin
        if (!bus.req[idx_q] || (MAX_HOLD != 8'd0 && hold_q == MAX_HOLD)) begin
          // Releasing rotates the current holder to lowest priority.
          timeout_d = bus.req[idx_q];
          valid_d   = 1'b0;
          onehot_d  = '0;
          ptr_d     = idx_q + 4'd1;
          state_d   = S_GAP;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end

      S_GAP: begin
        valid_d  = 1'b0;
        onehot_d = '0;
        state_d  = S_IDLE;
      end

      default: begin
        valid_d  = 1'b0;
        onehot_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      onehot_q  <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      onehot_q  <= onehot_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant_valid  = valid_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: four instances (MAX_HOLD 8, 4, 1, 0) share one request bus
// and are compared every cycle against a tenure-level reference model.
module tb_decoder_rr_arbiter;

  localparam int NI = 4;
  localparam int HOLD [NI] = '{8, 4, 1, 0};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req   = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decoder_rr_arbiter_if if0 ();
  decoder_rr_arbiter_if if1 ();
  decoder_rr_arbiter_if if2 ();
  decoder_rr_arbiter_if if3 ();

  assign if0.req = req;
  assign if1.req = req;
  assign if2.req = req;
  assign if3.req = req;

  decoder_rr_arbiter #(.MAX_HOLD(8'd8)) u_h8 (.clk(clk), .rst_n(rst_n), .bus(if0));
  decoder_rr_arbiter #(.MAX_HOLD(8'd4)) u_h4 (.clk(clk), .rst_n(rst_n), .bus(if1));
  decoder_rr_arbiter #(.MAX_HOLD(8'd1)) u_h1 (.clk(clk), .rst_n(rst_n), .bus(if2));
  decoder_rr_arbiter #(.MAX_HOLD(8'd0)) u_h0 (.clk(clk), .rst_n(rst_n), .bus(if3));

  wire [NI-1:0]       gv;
  wire [NI-1:0][3:0]  gi;
  wire [NI-1:0][15:0] oh;
  wire [NI-1:0]       to;

  assign gv[0] = if0.grant_valid;  assign gi[0] = if0.grant_idx;
  assign oh[0] = if0.grant_onehot; assign to[0] = if0.timeout;
  assign gv[1] = if1.grant_valid;  assign gi[1] = if1.grant_idx;
  assign oh[1] = if1.grant_onehot; assign to[1] = if1.timeout;
  assign gv[2] = if2.grant_valid;  assign gi[2] = if2.grant_idx;
  assign oh[2] = if2.grant_onehot; assign to[2] = if2.timeout;
  assign gv[3] = if3.grant_valid;  assign gi[3] = if3.grant_idx;
  assign oh[3] = if3.grant_onehot; assign to[3] = if3.timeout;

  // Reference model: who owns the resource, for how long, quiet cycles left, and last owner.
  int          m_owner [NI];
  int          m_held  [NI];
  int          m_cool  [NI];
  int          m_last  [NI];
  logic [3:0]  m_idx   [NI];
  logic        m_to    [NI];
  logic        m_gv    [NI];
  logic [15:0] m_oh    [NI];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_owner[k] = -1;
        m_held[k]  = 0;
        m_cool[k]  = 0;
        m_last[k]  = 15;
        m_idx[k]   = 4'd0;
        m_to[k]    = 1'b0;
      end else begin
        m_to[k] = 1'b0;
        if (m_owner[k] >= 0) begin
          if (!req[m_owner[k]]) begin
            m_last[k]  = m_owner[k];
            m_owner[k] = -1;
            m_cool[k]  = 1;
          end else if (HOLD[k] != 0 && m_held[k] == HOLD[k]) begin
            m_last[k]  = m_owner[k];
            m_owner[k] = -1;
            m_cool[k]  = 1;
            m_to[k]    = 1'b1;
          end else begin
            m_held[k] = m_held[k] + 1;
          end
        end else if (m_cool[k] > 0) begin
          m_cool[k] = m_cool[k] - 1;
        end else if (req != 16'd0) begin
          for (int off = 1; off <= 16; off++) begin
            int j;
            j = (m_last[k] + off) % 16;
            if (m_owner[k] < 0 && req[j]) begin
              m_owner[k] = j;
              m_held[k]  = 1;
              m_idx[k]   = 4'(j);
            end
          end
        end
      end
      m_gv[k] = (m_owner[k] >= 0);
      m_oh[k] = m_gv[k] ? (16'd1 << m_idx[k]) : 16'd0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({gv[k], gi[k], oh[k], to[k]} !== 22'd0) begin
        errors++;
        $display("FAIL reset inst%0d: got v=%b i=%0d oh=%h to=%b, expected all zero",
                 k, gv[k], gi[k], oh[k], to[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [15:0] exp_oh;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      req = (c <= 3) ? 16'h0001 : 16'h0000;
      next_cycle();
      exp_oh = (c <= 3) ? 16'h0001 : 16'h0000;
      checks++;
      if (gv[0] !== (c <= 3) || gi[0] !== 4'd0 || oh[0] !== exp_oh || to[0] !== 1'b0) begin
        errors++;
        $display("FAIL single c%0d: got v=%b i=%0d oh=%h to=%b, expected v=%b i=0 oh=%h to=0",
                 c, gv[0], gi[0], oh[0], to[0], (c <= 3), exp_oh);
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({gv[k], gi[k], oh[k], to[k]} !== {m_gv[k], m_idx[k], m_oh[k], m_to[k]}) begin
          errors++;
          $display("FAIL model_single inst%0d c%0d: got v=%b i=%0d oh=%h to=%b, expected v=%b i=%0d oh=%h to=%b",
                   k, c, gv[k], gi[k], oh[k], to[k], m_gv[k], m_idx[k], m_oh[k], m_to[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] exp_oh;
    logic        exp_to;
    int          phase;
    int          ten;
    do_reset();
    req = 16'h8001;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      phase  = (c - 1) % 6;
      ten    = (c - 1) / 6;
      exp_oh = (phase < 4) ? (((ten % 2) == 0) ? 16'h0001 : 16'h8000) : 16'h0000;
      exp_to = (phase == 4);
      checks++;
      if (oh[1] !== exp_oh || to[1] !== exp_to || gv[1] !== (phase < 4)) begin
        errors++;
        $display("FAIL timeout c%0d: got v=%b oh=%h to=%b, expected v=%b oh=%h to=%b",
                 c, gv[1], oh[1], to[1], (phase < 4), exp_oh, exp_to);
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({gv[k], gi[k], oh[k], to[k]} !== {m_gv[k], m_idx[k], m_oh[k], m_to[k]}) begin
          errors++;
          $display("FAIL model_timeout inst%0d c%0d: got v=%b i=%0d oh=%h to=%b, expected v=%b i=%0d oh=%h to=%b",
                   k, c, gv[k], gi[k], oh[k], to[k], m_gv[k], m_idx[k], m_oh[k], m_to[k]);
        end
      end
    end
  endtask

  task automatic test_rotate();
    logic [15:0] exp_oh;
    int          phase;
    int          t;
    do_reset();
    req = 16'hFFFF;
    for (int c = 1; c <= 51; c++) begin
      next_cycle();
      phase  = (c - 1) % 3;
      t      = (c - 1) / 3;
      exp_oh = (phase == 0) ? (16'd1 << (t % 16)) : 16'd0;
      checks++;
      if (oh[2] !== exp_oh || to[2] !== (phase == 1) ||
          (phase == 0 && gi[2] !== 4'(t % 16))) begin
        errors++;
        $display("FAIL rotate c%0d: got i=%0d oh=%h to=%b, expected i=%0d oh=%h to=%b",
                 c, gi[2], oh[2], to[2], t % 16, exp_oh, (phase == 1));
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({gv[k], gi[k], oh[k], to[k]} !== {m_gv[k], m_idx[k], m_oh[k], m_to[k]}) begin
          errors++;
          $display("FAIL model_rotate inst%0d c%0d: got v=%b i=%0d oh=%h to=%b, expected v=%b i=%0d oh=%h to=%b",
                   k, c, gv[k], gi[k], oh[k], to[k], m_gv[k], m_idx[k], m_oh[k], m_to[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 16'h0020;
    repeat (3) next_cycle();
    checks++;
    if (gv[0] !== 1'b1 || gi[0] !== 4'd5 || oh[0] !== 16'h0020) begin
      errors++;
      $display("FAIL pre_reset: got v=%b i=%0d oh=%h, expected v=1 i=5 oh=0020", gv[0], gi[0], oh[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({gv[k], gi[k], oh[k], to[k]} !== 22'd0) begin
        errors++;
        $display("FAIL async_reset inst%0d: got v=%b i=%0d oh=%h to=%b, expected all zero",
                 k, gv[k], gi[k], oh[k], to[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    checks++;
    if (gv[0] !== 1'b1 || gi[0] !== 4'd5 || oh[0] !== 16'h0020 || to[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got v=%b i=%0d oh=%h to=%b, expected v=1 i=5 oh=0020 to=0",
               gv[0], gi[0], oh[0], to[0]);
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({gv[k], gi[k], oh[k], to[k]} !== {m_gv[k], m_idx[k], m_oh[k], m_to[k]}) begin
        errors++;
        $display("FAIL model_async inst%0d: got v=%b i=%0d oh=%h to=%b, expected v=%b i=%0d oh=%h to=%b",
                 k, gv[k], gi[k], oh[k], to[k], m_gv[k], m_idx[k], m_oh[k], m_to[k]);
      end
    end
  endtask

  task automatic test_handover();
    logic [15:0] exp_oh;
    do_reset();
    req = 16'h0008;
    repeat (2) next_cycle();
    checks++;
    if (oh[0] !== 16'h0008 || gi[0] !== 4'd3) begin
      errors++;
      $display("FAIL handover_grant3: got i=%0d oh=%h, expected i=3 oh=0008", gi[0], oh[0]);
    end
    req = 16'h0200;
    for (int c = 3; c <= 6; c++) begin
      next_cycle();
      exp_oh = (c < 5) ? 16'h0000 : 16'h0200;
      checks++;
      if (oh[0] !== exp_oh || $countones(oh[0]) > 1) begin
        errors++;
        $display("FAIL handover c%0d: got oh=%h, expected oh=%h", c, oh[0], exp_oh);
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({gv[k], gi[k], oh[k], to[k]} !== {m_gv[k], m_idx[k], m_oh[k], m_to[k]}) begin
          errors++;
          $display("FAIL model_handover inst%0d c%0d: got v=%b i=%0d oh=%h to=%b, expected v=%b i=%0d oh=%h to=%b",
                   k, c, gv[k], gi[k], oh[k], to[k], m_gv[k], m_idx[k], m_oh[k], m_to[k]);
        end
      end
    end
  endtask

  task automatic test_unlimited();
    do_reset();
    req = 16'h0010;
    for (int c = 1; c <= 1000; c++) begin
      next_cycle();
      checks++;
      if (gv[3] !== 1'b1 || gi[3] !== 4'd4 || oh[3] !== 16'h0010 || to[3] !== 1'b0) begin
        errors++;
        $display("FAIL unlimited c%0d: got v=%b i=%0d oh=%h to=%b, expected v=1 i=4 oh=0010 to=0",
                 c, gv[3], gi[3], oh[3], to[3]);
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({gv[k], gi[k], oh[k], to[k]} !== {m_gv[k], m_idx[k], m_oh[k], m_to[k]}) begin
          errors++;
          $display("FAIL model_unlimited inst%0d c%0d: got v=%b i=%0d oh=%h to=%b, expected v=%b i=%0d oh=%h to=%b",
                   k, c, gv[k], gi[k], oh[k], to[k], m_gv[k], m_idx[k], m_oh[k], m_to[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 1; c <= 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = 16'($urandom);
          1:       req = 16'd1 << $urandom_range(0, 15);
          2:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
          default: req = 16'h0000;
        endcase
      end
      next_cycle();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({gv[k], gi[k], oh[k], to[k]} !== {m_gv[k], m_idx[k], m_oh[k], m_to[k]} ||
            $countones(oh[k]) > 1) begin
          errors++;
          $display("FAIL model_random inst%0d c%0d: got v=%b i=%0d oh=%h to=%b, expected v=%b i=%0d oh=%h to=%b",
                   k, c, gv[k], gi[k], oh[k], to[k], m_gv[k], m_idx[k], m_oh[k], m_to[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_rotate();
    test_async_reset();
    test_handover();
    test_unlimited();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
